// File: rtl/hansen_dmem_if.sv
// Bus bundle for hansen_dmem: the core's data-memory port plus the TX byte stream.
// The master side stands for everything outside the block (core and byte consumer).
interface hansen_dmem_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;

    modport master (
        output dmem_addr, dmem_wdata, dmem_we, io_tx_ready,
        input  dmem_rdata, io_tx_data, io_tx_valid
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_we, io_tx_ready,
        output dmem_rdata, io_tx_data, io_tx_valid
    );
endinterface

// File: rtl/hansen_dmem.sv
// Data memory for a single-cycle core: zero-latency RAM reads, a TX byte FIFO
// and a compare-match timer, all behind one word-aligned memory map.
module hansen_dmem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    hansen_dmem_if.slave  bus,
    output logic          timer_irq,
    output logic          bus_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
    localparam logic [31:0] ADDR_TCOUNT = 32'h8000_0008;
    localparam logic [31:0] ADDR_TCMP   = 32'h8000_000C;
    localparam logic [31:0] ADDR_TCTRL  = 32'h8000_0010;
    localparam logic [31:0] ADDR_IRQ    = 32'h8000_0014;

    logic          aligned, in_ram, mapped, store;
    logic          sel_tx, sel_status, sel_tcount, sel_tcmp, sel_tctrl, sel_irq;
    logic [AW-1:0] ram_idx;

    assign aligned    = (bus.dmem_addr[1:0] == 2'b00);
    assign in_ram     = (bus.dmem_addr[31:AW+2] == '0);
    assign ram_idx    = bus.dmem_addr[AW+1:2];
    assign sel_tx     = (bus.dmem_addr == ADDR_TXDATA);
    assign sel_status = (bus.dmem_addr == ADDR_STATUS);
    assign sel_tcount = (bus.dmem_addr == ADDR_TCOUNT);
    assign sel_tcmp   = (bus.dmem_addr == ADDR_TCMP);
    assign sel_tctrl  = (bus.dmem_addr == ADDR_TCTRL);
    assign sel_irq    = (bus.dmem_addr == ADDR_IRQ);
    assign mapped     = in_ram | sel_tx | sel_status | sel_tcount | sel_tcmp | sel_tctrl | sel_irq;
    assign store      = bus.dmem_we;

    logic [31:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (store && aligned && in_ram)
            ram[ram_idx] <= bus.dmem_wdata;
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty, pop, push_req, push, drop;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && bus.io_tx_ready;
    assign push_req   = store && sel_tx;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.dmem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.io_tx_data  = fifo_mem[rd_ptr];
    assign bus.io_tx_valid = !fifo_empty;

    logic ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf     <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= (store && (!aligned || !mapped)) || drop;
            if (drop)
                ovf <= 1'b1;
            else if (store && sel_status && bus.dmem_wdata[6])
                ovf <= 1'b0;
        end
    end

    logic [31:0] tcount, tcmp;
    logic [1:0]  tctrl;
    logic        irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcount <= '0;
            tcmp   <= '0;
            tctrl  <= '0;
            irq    <= 1'b0;
        end else begin
            if (store && sel_tcount)
                tcount <= bus.dmem_wdata;
            else if (tctrl[0])
                tcount <= tcount + 32'd1;
            if (store && sel_tcmp)
                tcmp <= bus.dmem_wdata;
            if (store && sel_tctrl)
                tctrl <= bus.dmem_wdata[1:0];
            // Match uses the pre-edge count; a simultaneous clear loses to the set.
            if (tctrl[0] && (tcount == tcmp))
                irq <= 1'b1;
            else if (store && sel_irq && bus.dmem_wdata[0])
                irq <= 1'b0;
        end
    end

    assign timer_irq = irq && tctrl[1];

    always_comb begin
        bus.dmem_rdata = '0;
        if (aligned) begin
            if (in_ram)
                bus.dmem_rdata = ram[ram_idx];
            else if (sel_status)
                bus.dmem_rdata = {25'b0, ovf, 4'(count), fifo_empty, fifo_full};
            else if (sel_tcount)
                bus.dmem_rdata = tcount;
            else if (sel_tcmp)
                bus.dmem_rdata = tcmp;
            else if (sel_tctrl)
                bus.dmem_rdata = {30'b0, tctrl};
            else if (sel_irq)
                bus.dmem_rdata = {31'b0, irq};
        end
    end
endmodule

// File: tb/tb_hansen_dmem.sv
// Directed bench for hansen_dmem: a queue/array model is checked against the
// DUT every mid-cycle, with literal expectations pinning the key scenarios.
module tb_hansen_dmem;
    localparam int DEPTH = 1024;
    localparam int FD    = 4;

    localparam logic [31:0] TX     = 32'h8000_0000;
    localparam logic [31:0] STATUS = 32'h8000_0004;
    localparam logic [31:0] TCOUNT = 32'h8000_0008;
    localparam logic [31:0] TCMP   = 32'h8000_000C;
    localparam logic [31:0] TCTRL  = 32'h8000_0010;
    localparam logic [31:0] IRQ    = 32'h8000_0014;

    logic clk;
    logic reset_n;
    logic timer_irq;
    logic bus_err;

    hansen_dmem_if bus();

    hansen_dmem #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] mRam [int unsigned];
    logic [7:0]  mQ [$];
    logic        mOvf = 1'b0;
    logic [31:0] mTcount = '0;
    logic [31:0] mTcmp = '0;
    logic [1:0]  mTctrl = '0;
    logic        mIrq = 1'b0;
    logic        mErr = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mOvf    = 1'b0;
        mTcount = '0;
        mTcmp   = '0;
        mTctrl  = '0;
        mIrq    = 1'b0;
        mErr    = 1'b0;
    endtask

    // One clock edge of the memory map, written from the register/FIFO rules.
    task automatic modelStep(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        bit          wasFull  = (mQ.size() == FD);
        bit          popNow   = (mQ.size() != 0) && rdy;
        bit          setIrq   = mTctrl[0] && (mTcount == mTcmp);
        logic [31:0] newCount = mTctrl[0] ? mTcount + 32'd1 : mTcount;
        mErr = 1'b0;
        if (popNow) void'(mQ.pop_front());
        if (we) begin
            if (a[1:0] != 2'b00) mErr = 1'b1;
            else if (a < DEPTH * 4) mRam[a >> 2] = d;
            else begin
                case (a)
                    TX:      if (!wasFull || popNow) mQ.push_back(d[7:0]);
                             else begin mOvf = 1'b1; mErr = 1'b1; end
                    STATUS:  if (d[6]) mOvf = 1'b0;
                    TCOUNT:  newCount = d;
                    TCMP:    mTcmp = d;
                    TCTRL:   mTctrl = d[1:0];
                    IRQ:     if (d[0]) mIrq = 1'b0;
                    default: mErr = 1'b1;
                endcase
            end
        end
        mTcount = newCount;
        if (setIrq) mIrq = 1'b1;
    endtask

    function automatic void modelRead(input logic [31:0] a, output bit known, output logic [31:0] v);
        known = 1'b1;
        v     = '0;
        if (a[1:0] != 2'b00) return;
        if (a < DEPTH * 4) begin
            if (mRam.exists(a >> 2)) v = mRam[a >> 2];
            else known = 1'b0;
        end else begin
            case (a)
                TX:     known = 1'b0;
                STATUS: v = {25'b0, mOvf, 4'(mQ.size()), mQ.size() == 0, mQ.size() == FD};
                TCOUNT: v = mTcount;
                TCMP:   v = mTcmp;
                TCTRL:  v = {30'b0, mTctrl};
                IRQ:    v = {31'b0, mIrq};
                default: v = '0;
            endcase
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else modelStep(bus.dmem_addr, bus.dmem_wdata, bus.dmem_we, bus.io_tx_ready);
    end

    // Mid-cycle compare: inputs are stable and the last edge has settled.
    always @(negedge clk) begin
        bit          known;
        logic [31:0] expRd;
        if (!reset_n) begin
            checkOutput("rst_tx_valid", bus.io_tx_valid, 0);
            checkOutput("rst_timer_irq", timer_irq, 0);
            checkOutput("rst_bus_err", bus_err, 0);
        end else begin
            checkOutput("tx_valid", bus.io_tx_valid, mQ.size() != 0);
            if (mQ.size() != 0) checkOutput("tx_data", bus.io_tx_data, mQ[0]);
            checkOutput("timer_irq", timer_irq, mIrq && mTctrl[1]);
            checkOutput("bus_err", bus_err, mErr);
            modelRead(bus.dmem_addr, known, expRd);
            if (known) checkOutput("rdata", bus.dmem_rdata, expRd);
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        @(posedge clk);
        #1;
        bus.dmem_addr   = a;
        bus.dmem_wdata  = d;
        bus.dmem_we     = we;
        bus.io_tx_ready = rdy;
        #2;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.dmem_addr   = '0;
        bus.dmem_wdata  = '0;
        bus.dmem_we     = 1'b0;
        bus.io_tx_ready = 1'b0;
        repeat (3) applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_valid", bus.io_tx_valid, 0);
        checkOutput("reset_bus_err", bus_err, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("status_after_reset", bus.dmem_rdata, 32'h2);

        // RAM write then zero-cycle read, misaligned read returns 0
        applyStimulus(32'h10, 32'hDEAD_BEEF, 1, 0);
        applyStimulus(32'h10, 0, 0, 0);
        checkOutput("ram_read_back", bus.dmem_rdata, 32'hDEAD_BEEF);
        applyStimulus(32'h11, 0, 0, 0);
        checkOutput("misaligned_read", bus.dmem_rdata, 32'h0);

        // Rejected stores: misaligned and unmapped
        applyStimulus(32'h12, 32'h1234_5678, 1, 0);
        applyStimulus(32'h10, 0, 0, 0);
        checkOutput("err_misaligned", bus_err, 1);
        checkOutput("ram_kept_1", bus.dmem_rdata, 32'hDEAD_BEEF);
        applyStimulus(32'h4000_0000, 32'hCAFE_F00D, 1, 0);
        checkOutput("err_one_cycle", bus_err, 0);
        applyStimulus(32'h10, 0, 0, 0);
        checkOutput("err_unmapped", bus_err, 1);
        checkOutput("ram_kept_2", bus.dmem_rdata, 32'hDEAD_BEEF);
        applyStimulus(32'h8000_0018, 0, 0, 0);
        checkOutput("err_cleared", bus_err, 0);
        checkOutput("unmapped_read", bus.dmem_rdata, 32'h0);

        // Overfill with ready low, then drain in order
        for (int i = 0; i < 5; i++) applyStimulus(TX, 32'h41 + i, 1, 0);
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("status_full_ovf", bus.dmem_rdata, 32'h51);
        checkOutput("err_overflow", bus_err, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(STATUS, 0, 0, 1);
            checkOutput("drain_byte", bus.io_tx_data, 32'h41 + i);
        end
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("status_empty_ovf", bus.dmem_rdata, 32'h42);
        checkOutput("drained_valid", bus.io_tx_valid, 0);
        applyStimulus(STATUS, 32'h40, 1, 0);
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("ovf_cleared", bus.dmem_rdata, 32'h2);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++) applyStimulus(TX, 32'h50 + i, 1, 0);
        applyStimulus(TX, 32'h54, 1, 1);
        checkOutput("head_before_swap", bus.io_tx_data, 32'h50);
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("status_full_no_ovf", bus.dmem_rdata, 32'h11);
        checkOutput("swap_no_err", bus_err, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(STATUS, 0, 0, 1);
            checkOutput("swap_drain", bus.io_tx_data, 32'h51 + i);
        end
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("swap_empty", bus.dmem_rdata, 32'h2);

        // Timer: match on pre-edge count of 5, clear, store override, wrap
        applyStimulus(TCMP, 5, 1, 0);
        applyStimulus(TCOUNT, 0, 1, 0);
        applyStimulus(TCTRL, 3, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(TCOUNT, 0, 0, 0);
            checkOutput("tcount_step", bus.dmem_rdata, k - 1);
            checkOutput("irq_rise", timer_irq, (k >= 7) ? 1 : 0);
        end
        applyStimulus(IRQ, 1, 1, 0);
        applyStimulus(IRQ, 0, 0, 0);
        checkOutput("irq_cleared", timer_irq, 0);
        checkOutput("irq_reg_read", bus.dmem_rdata, 0);
        applyStimulus(TCOUNT, 32'h100, 1, 0);
        applyStimulus(TCOUNT, 0, 0, 0);
        checkOutput("tcount_store_wins", bus.dmem_rdata, 32'h100);
        applyStimulus(TCOUNT, 32'hFFFF_FFFF, 1, 0);
        applyStimulus(TCOUNT, 0, 0, 0);
        checkOutput("tcount_max", bus.dmem_rdata, 32'hFFFF_FFFF);
        applyStimulus(TCOUNT, 0, 0, 0);
        checkOutput("tcount_wrap", bus.dmem_rdata, 32'h0);
        applyStimulus(TCTRL, 0, 1, 0);
        applyStimulus(TCTRL, 0, 0, 0);
        checkOutput("tctrl_read", bus.dmem_rdata, 32'h0);

        // Reset mid-drain with three bytes queued
        for (int i = 0; i < 4; i++) applyStimulus(TX, 32'h60 + i, 1, 0);
        applyStimulus(STATUS, 0, 0, 1);
        applyStimulus(STATUS, 0, 0, 1);
        checkOutput("three_queued", bus.dmem_rdata, 32'h0C);
        reset_n = 1'b0;
        #1;
        checkOutput("async_valid_drop", bus.io_tx_valid, 0);
        checkOutput("async_bus_err", bus_err, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(STATUS, 0, 0, 0);
        checkOutput("status_post_reset", bus.dmem_rdata, 32'h2);
        checkOutput("valid_post_reset", bus.io_tx_valid, 0);

        repeat (2) applyStimulus(32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
